// File: rtl/math_pkg.sv
// Shared definitions for the sequential multiply/divide unit: operation codes,
// FSM states and small op-decoding helpers.
package math_pkg;

  localparam logic [1:0] OP_MULU = 2'b00;
  localparam logic [1:0] OP_MULS = 2'b01;
  localparam logic [1:0] OP_DIVU = 2'b10;
  localparam logic [1:0] OP_DIVS = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIVU) || (op == OP_DIVS);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULS) || (op == OP_DIVS);
  endfunction

endpackage

// File: rtl/math_iter_core.sv
// Iterative datapath on unsigned magnitudes: shift-add multiply or restoring
// shift-subtract divide, one bit per step. raw_hi/raw_lo show the post-step values.
module math_iter_core #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] mag_a,
  input  logic [WIDTH-1:0] mag_b,
  output logic [WIDTH-1:0] raw_hi,
  output logic [WIDTH-1:0] raw_lo
);

  logic [WIDTH-1:0] acc_q, acc_d, sh_q, sh_d, opb_q, opb_d;
  logic [WIDTH-1:0] acc_s, sh_s;
  logic [WIDTH:0]   sum, shifted, trial;

  always_comb begin
    sum     = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opb_q} : '0);
    shifted = {acc_q, sh_q[WIDTH-1]};
    trial   = shifted - {1'b0, opb_q};
    // Partial remainder stays below the divisor, so bit WIDTH of trial is the borrow.
    if (is_div) begin
      if (!trial[WIDTH]) begin
        acc_s = trial[WIDTH-1:0];
        sh_s  = {sh_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_s = shifted[WIDTH-1:0];
        sh_s  = {sh_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      {acc_s, sh_s} = {sum, sh_q[WIDTH-1:1]};
    end

    acc_d = acc_q;
    sh_d  = sh_q;
    opb_d = opb_q;
    if (load) begin
      acc_d = '0;
      sh_d  = mag_a;
      opb_d = mag_b;
    end else if (step) begin
      acc_d = acc_s;
      sh_d  = sh_s;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      sh_q  <= '0;
      opb_q <= '0;
    end else begin
      acc_q <= acc_d;
      sh_q  <= sh_d;
      opb_q <= opb_d;
    end
  end

  assign raw_hi = acc_s;
  assign raw_lo = sh_s;

endmodule

// File: rtl/seq_math_unit.sv
// Multi-cycle multiply/divide unit with start/busy/done handshake. Holds the FSM,
// iteration counter, sign fix-up and the divide-by-zero / overflow flags.
module seq_math_unit
  import math_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_zero,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             neg_res_q, neg_res_d, neg_rem_q, neg_rem_d, ovf_pend_q, ovf_pend_d;
  logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d, ov_q, ov_d;
  logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;

  logic             accept, neg_a, neg_b, core_load, core_step;
  logic [WIDTH-1:0] mag_a, mag_b, raw_hi, raw_lo;
  logic [2*WIDTH-1:0] prod;

  math_iter_core #(.WIDTH(WIDTH)) u_core (
    .clock  (clock),
    .reset  (reset),
    .load   (core_load),
    .step   (core_step),
    .is_div (op_is_div(op_q)),
    .mag_a  (mag_a),
    .mag_b  (mag_b),
    .raw_hi (raw_hi),
    .raw_lo (raw_lo)
  );

  always_comb begin
    neg_a  = op_is_signed(op) && a[WIDTH-1];
    neg_b  = op_is_signed(op) && b[WIDTH-1];
    // Unsigned WIDTH-bit magnitude keeps 2^(WIDTH-1) exact for the most-negative value.
    mag_a  = neg_a ? -a : a;
    mag_b  = neg_b ? -b : b;
    accept = start && (state_q != S_RUN);
    prod   = neg_res_q ? -{raw_hi, raw_lo} : {raw_hi, raw_lo};

    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    ovf_pend_d = ovf_pend_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    dz_d       = dz_q;
    ov_d       = ov_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    core_load  = 1'b0;
    core_step  = 1'b0;

    case (state_q)
      S_RUN: begin
        core_step = 1'b1;
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          if (op_is_div(op_q)) begin
            lo_d = neg_res_q ? -raw_lo : raw_lo;
            hi_d = neg_rem_q ? -raw_hi : raw_hi;
            ov_d = ovf_pend_q;
          end else begin
            {hi_d, lo_d} = prod;
          end
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        if (accept) begin
          op_d       = op;
          neg_res_d  = neg_a ^ neg_b;
          neg_rem_d  = neg_a;
          ovf_pend_d = (op == OP_DIVS) && (a == MOST_NEG) && (b == '1);
          cnt_d      = CNT_W'(WIDTH);
          dz_d       = 1'b0;
          ov_d       = 1'b0;
          if (op_is_div(op) && (b == '0)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            lo_d    = '1;
            hi_d    = a;
            dz_d    = 1'b1;
          end else begin
            state_d   = S_RUN;
            busy_d    = 1'b1;
            core_load = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= OP_MULU;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dz_q       <= 1'b0;
      ov_q       <= 1'b0;
      lo_q       <= '0;
      hi_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dz_q       <= dz_d;
      ov_q       <= ov_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result_lo = lo_q;
  assign result_hi = hi_q;
  assign div_zero  = dz_q;
  assign overflow  = ov_q;

endmodule

// File: tb/tb_seq_math_unit.sv
// Directed bench for seq_math_unit at WIDTH 8, 16 and 32: a vector table plus
// hand-written handshake and asynchronous-reset sequences.
module tb_seq_math_unit;
  import math_pkg::*;

  typedef struct {
    int          w;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
    logic        ov;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start8 = 1'b0, start16 = 1'b0, start32 = 1'b0;
  logic [1:0]  op_in = OP_MULU;
  logic [31:0] a_in = '0, b_in = '0;
  int          sel_w = 16;

  logic        busy8, done8, dz8, ov8;
  logic [7:0]  lo8, hi8;
  logic        busy16, done16, dz16, ov16;
  logic [15:0] lo16, hi16;
  logic        busy32, done32, dz32, ov32;
  logic [31:0] lo32, hi32;

  logic        done_s, busy_s, dz_s, ov_s;
  logic [31:0] lo_s, hi_s;

  int n_pass = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  seq_math_unit #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .op(op_in), .a(a_in[7:0]), .b(b_in[7:0]),
    .busy(busy8), .done(done8), .result_lo(lo8), .result_hi(hi8), .div_zero(dz8), .overflow(ov8)
  );

  seq_math_unit #(.WIDTH(16)) dut16 (
    .clock(clock), .reset(reset), .start(start16), .op(op_in), .a(a_in[15:0]), .b(b_in[15:0]),
    .busy(busy16), .done(done16), .result_lo(lo16), .result_hi(hi16), .div_zero(dz16), .overflow(ov16)
  );

  seq_math_unit #(.WIDTH(32)) dut32 (
    .clock(clock), .reset(reset), .start(start32), .op(op_in), .a(a_in), .b(b_in),
    .busy(busy32), .done(done32), .result_lo(lo32), .result_hi(hi32), .div_zero(dz32), .overflow(ov32)
  );

  always_comb begin
    case (sel_w)
      8: begin
        done_s = done8; busy_s = busy8; dz_s = dz8; ov_s = ov8;
        lo_s = {24'b0, lo8}; hi_s = {24'b0, hi8};
      end
      32: begin
        done_s = done32; busy_s = busy32; dz_s = dz32; ov_s = ov32;
        lo_s = lo32; hi_s = hi32;
      end
      default: begin
        done_s = done16; busy_s = busy16; dz_s = dz16; ov_s = ov16;
        lo_s = {16'b0, lo16}; hi_s = {16'b0, hi16};
      end
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic set_start(input int w, input logic v);
    start8  = (w == 8)  ? v : 1'b0;
    start16 = (w == 16) ? v : 1'b0;
    start32 = (w == 32) ? v : 1'b0;
  endtask

  // Counts cycles after the start edge until done; busy counted on non-done cycles.
  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc  = 0;
    while (lat < 200) begin
      @(negedge clock);
      lat++;
      if (done_s) break;
      if (busy_s) bc++;
    end
  endtask

  task automatic issue(input int w, input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb);
    sel_w = w;
    op_in = o;
    a_in  = aa;
    b_in  = bb;
    set_start(w, 1'b1);
    @(posedge clock);
    #1;
    set_start(w, 1'b0);
  endtask

  initial begin
    int lat, bc, extra;

    vecs[0]  = '{16, OP_MULU, 32'd10,       32'd29,       17, 32'd290,      32'd0,        1'b0, 1'b0};
    vecs[1]  = '{16, OP_MULU, 32'd0,        32'd100,      17, 32'd0,        32'd0,        1'b0, 1'b0};
    vecs[2]  = '{16, OP_MULU, 32'hFFFF,     32'hFFFF,     17, 32'h0001,     32'hFFFE,     1'b0, 1'b0};
    vecs[3]  = '{16, OP_MULS, 32'hFFFD,     32'd7,        17, 32'hFFEB,     32'hFFFF,     1'b0, 1'b0};
    vecs[4]  = '{16, OP_DIVS, 32'hFFF9,     32'd2,        17, 32'hFFFD,     32'hFFFF,     1'b0, 1'b0};
    vecs[5]  = '{16, OP_DIVS, 32'h8000,     32'hFFFF,     17, 32'h8000,     32'h0000,     1'b0, 1'b1};
    vecs[6]  = '{16, OP_DIVU, 32'd4235,     32'd10,       17, 32'd423,      32'd5,        1'b0, 1'b0};
    vecs[7]  = '{16, OP_DIVU, 32'd1,        32'd0,        1,  32'hFFFF,     32'd1,        1'b1, 1'b0};
    vecs[8]  = '{16, OP_MULU, 32'd3,        32'd5,        17, 32'd15,       32'd0,        1'b0, 1'b0};
    vecs[9]  = '{16, OP_MULS, 32'h8000,     32'h8000,     17, 32'h0000,     32'h4000,     1'b0, 1'b0};
    vecs[10] = '{16, OP_DIVS, 32'd7,        32'hFFFE,     17, 32'hFFFD,     32'd1,        1'b0, 1'b0};
    vecs[11] = '{16, OP_DIVS, 32'hFFF9,     32'd0,        1,  32'hFFFF,     32'hFFF9,     1'b1, 1'b0};
    vecs[12] = '{8,  OP_MULU, 32'd10,       32'd29,       9,  32'h22,       32'h01,       1'b0, 1'b0};
    vecs[13] = '{8,  OP_DIVU, 32'd235,      32'd10,       9,  32'd23,       32'd5,        1'b0, 1'b0};
    vecs[14] = '{8,  OP_DIVU, 32'd1,        32'd0,        1,  32'hFF,       32'd1,        1'b1, 1'b0};
    vecs[15] = '{8,  OP_MULS, 32'h80,       32'h80,       9,  32'h00,       32'h40,       1'b0, 1'b0};
    vecs[16] = '{32, OP_MULU, 32'd10,       32'd29,       33, 32'd290,      32'd0,        1'b0, 1'b0};
    vecs[17] = '{32, OP_DIVU, 32'd4235,     32'd10,       33, 32'd423,      32'd5,        1'b0, 1'b0};
    vecs[18] = '{32, OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[19] = '{32, OP_DIVS, 32'h80000000, 32'hFFFFFFFF, 33, 32'h80000000, 32'h0,        1'b0, 1'b1};

    repeat (2) @(negedge clock);
    chk("rst_busy", {31'b0, busy16}, 32'd0);
    chk("rst_done", {31'b0, done16}, 32'd0);
    chk("rst_lo",   {16'b0, lo16},   32'd0);
    chk("rst_hi",   {16'b0, hi16},   32'd0);
    chk("rst_dz",   {31'b0, dz16},   32'd0);
    chk("rst_ov",   {31'b0, ov16},   32'd0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < NV; i++) begin
      @(negedge clock);
      issue(vecs[i].w, vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(lat, bc);
      $display("vec %0d w=%0d op=%0d a=%h b=%h -> lo=%h hi=%h dz=%b ov=%b lat=%0d busy=%0d",
               i, vecs[i].w, vecs[i].op, vecs[i].a, vecs[i].b, lo_s, hi_s, dz_s, ov_s, lat, bc);
      chk($sformatf("v%0d_lat", i),  32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_busy", i), 32'(bc),  32'(vecs[i].lat - 1));
      chk($sformatf("v%0d_lo", i),   lo_s, vecs[i].lo);
      chk($sformatf("v%0d_hi", i),   hi_s, vecs[i].hi);
      chk($sformatf("v%0d_dz", i),   {31'b0, dz_s}, {31'b0, vecs[i].dz});
      chk($sformatf("v%0d_ov", i),   {31'b0, ov_s}, {31'b0, vecs[i].ov});
    end

    // start held high throughout RUN must not be queued
    @(negedge clock);
    sel_w = 16; op_in = OP_MULU; a_in = 32'd10; b_in = 32'd29; start16 = 1'b1;
    @(posedge clock);
    #1;
    a_in = 32'd3; b_in = 32'd3;
    lat = 0;
    while (lat < 200) begin
      @(negedge clock);
      lat++;
      if (lat == 16) start16 = 1'b0;
      if (done16) break;
    end
    start16 = 1'b0;
    $display("ignore-while-busy: lat=%0d lo=%h", lat, lo16);
    chk("ign_lat", 32'(lat), 32'd17);
    chk("ign_lo", {16'b0, lo16}, 32'd290);
    extra = 0;
    repeat (25) begin
      @(negedge clock);
      if (done16) extra++;
    end
    chk("ign_extra_done", 32'(extra), 32'd0);

    // start in the DONE cycle is accepted back-to-back
    @(negedge clock);
    issue(16, OP_MULU, 32'd10, 32'd29);
    wait_done(lat, bc);
    chk("b2b_first_lat", 32'(lat), 32'd17);
    op_in = OP_MULU; a_in = 32'd6; b_in = 32'd7; start16 = 1'b1;
    @(posedge clock);
    #1;
    start16 = 1'b0;
    wait_done(lat, bc);
    $display("back-to-back: lat=%0d busy=%0d lo=%h hi=%h", lat, bc, lo16, hi16);
    chk("b2b_gap", 32'(lat), 32'd17);
    chk("b2b_busy", 32'(bc), 32'd16);
    chk("b2b_lo", {16'b0, lo16}, 32'd42);
    chk("b2b_hi", {16'b0, hi16}, 32'd0);

    // asynchronous reset between clock edges mid-RUN
    @(negedge clock);
    issue(16, OP_DIVU, 32'd4235, 32'd10);
    repeat (5) @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    $display("async reset: busy=%b done=%b lo=%h hi=%h", busy16, done16, lo16, hi16);
    chk("arst_busy", {31'b0, busy16}, 32'd0);
    chk("arst_done", {31'b0, done16}, 32'd0);
    chk("arst_lo",   {16'b0, lo16},   32'd0);
    chk("arst_hi",   {16'b0, hi16},   32'd0);
    chk("arst_dz",   {31'b0, dz16},   32'd0);
    chk("arst_ov",   {31'b0, ov16},   32'd0);
    @(negedge clock);
    reset = 1'b0;
    extra = 0;
    repeat (25) begin
      @(negedge clock);
      if (done16) extra++;
    end
    chk("arst_no_done", 32'(extra), 32'd0);

    @(negedge clock);
    issue(16, OP_DIVU, 32'd4235, 32'd10);
    wait_done(lat, bc);
    $display("after reset: lat=%0d lo=%h hi=%h", lat, lo16, hi16);
    chk("post_lat", 32'(lat), 32'd17);
    chk("post_lo", {16'b0, lo16}, 32'd423);
    chk("post_hi", {16'b0, hi16}, 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
